// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
//   Shared types for the bit-serial adder.
//   serial_adder_state_e : controller state (Idle / Busy / Done).
package serial_adder_pkg;

  typedef enum logic [1:0] {
    Idle = 2'b00,
    Busy = 2'b01,
    Done = 2'b10
  } serial_adder_state_e;

endpackage

// File: rtl/full_adder.sv
// full_adder
//   Single-bit combinational full adder.
//   in1_i, in2_i : operand bits
//   carry_i      : carry-in
//   sum_o        : in1_i ^ in2_i ^ carry_i
//   carry_o      : majority(in1_i, in2_i, carry_i)
module full_adder (
  input  logic in1_i,
  input  logic in2_i,
  input  logic carry_i,
  output logic sum_o,
  output logic carry_o
);

  assign sum_o   = in1_i ^ in2_i ^ carry_i;
  assign carry_o = (in1_i & in2_i) | (in1_i & carry_i) | (in2_i & carry_i);

endmodule

// File: rtl/serial_adder.sv
// serial_adder
//   Bit-serial adder: one full_adder processes one bit pair per cycle,
//   LSB first, with the carry held in a register between cycles.
//   Width        : operand / sum width (2..64)
//   clk_i        : clock, rising edge
//   rst_ni       : asynchronous active-low reset
//   in_valid_i   : operand request valid
//   in_ready_o   : ready to accept operands (Idle only)
//   a_i, b_i     : operands
//   carry_i      : carry-in for this operation
//   out_valid_o  : result valid (Done only)
//   out_ready_i  : consumer accepts the result
//   sum_o        : (a + b + carry_i) mod 2^Width
//   carry_o      : carry-out of bit Width-1
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  input  logic             carry_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [Width-1:0] sum_o,
  output logic             carry_o
);

  localparam int unsigned CntW = $clog2(Width);
  localparam logic [CntW-1:0] CntLast = CntW'(Width - 1);

  serial_adder_state_e state_q, state_d;
  logic [Width-1:0]    a_q, a_d;
  logic [Width-1:0]    b_q, b_d;
  logic [Width-1:0]    sum_q, sum_d;
  logic                carry_q, carry_d;
  logic [CntW-1:0]     cnt_q, cnt_d;

  logic                fa_sum;
  logic                fa_carry;

  full_adder u_full_adder (
    .in1_i   (a_q[0]),
    .in2_i   (b_q[0]),
    .carry_i (carry_q),
    .sum_o   (fa_sum),
    .carry_o (fa_carry)
  );

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;

    unique case (state_q)
      Idle: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          a_d     = a_i;
          b_d     = b_i;
          sum_d   = '0;
          carry_d = carry_i;
          cnt_d   = '0;
          state_d = Busy;
        end
      end

      Busy: begin
        // Sum bits enter at the MSB; after Width shifts bit 0 sits at the LSB.
        a_d     = {1'b0, a_q[Width-1:1]};
        b_d     = {1'b0, b_q[Width-1:1]};
        sum_d   = {fa_sum, sum_q[Width-1:1]};
        carry_d = fa_carry;
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          state_d = Done;
        end
      end

      Done: begin
        out_valid_o = 1'b1;
        if (out_ready_i) begin
          state_d = Idle;
        end
      end

      default: begin
        state_d = Idle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= Idle;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sum_o   = sum_q;
  assign carry_o = carry_q;

`ifndef SYNTHESIS
  a_ready_valid_exclusive : assert property (
    @(posedge clk_i) disable iff (!rst_ni) !(in_ready_o && out_valid_o)
  );

  a_output_stable : assert property (
    @(posedge clk_i) disable iff (!rst_ni)
      (out_valid_o && !out_ready_i) |=> ($stable(sum_o) && $stable(carry_o))
  );
`endif

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // ---------------- Width = 8 instance ----------------
  logic       rst8_n, iv8, ir8, c8, ov8, or8, co8;
  logic [7:0] a8, b8, s8;
  logic [8:0] q8[$];
  int         acc8 = 0;
  int         res8 = 0;

  serial_adder #(.Width(8)) u_dut8 (
    .clk_i       (clk),
    .rst_ni      (rst8_n),
    .in_valid_i  (iv8),
    .in_ready_o  (ir8),
    .a_i         (a8),
    .b_i         (b8),
    .carry_i     (c8),
    .out_valid_o (ov8),
    .out_ready_i (or8),
    .sum_o       (s8),
    .carry_o     (co8)
  );

  // ---------------- Width = 32 instance ----------------
  logic        rst32_n, iv32, ir32, c32, ov32, or32, co32;
  logic [31:0] a32, b32, s32;
  logic [32:0] q32[$];
  int          res32 = 0;

  serial_adder #(.Width(32)) u_dut32 (
    .clk_i       (clk),
    .rst_ni      (rst32_n),
    .in_valid_i  (iv32),
    .in_ready_o  (ir32),
    .a_i         (a32),
    .b_i         (b32),
    .carry_i     (c32),
    .out_valid_o (ov32),
    .out_ready_i (or32),
    .sum_o       (s32),
    .carry_o     (co32)
  );

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: plain integer addition, pushed when a request is accepted.
  always @(negedge clk) begin
    if (rst8_n && iv8 && ir8) begin
      q8.push_back(9'(a8) + 9'(b8) + 9'(c8));
      acc8++;
    end
    if (rst32_n && iv32 && ir32) begin
      q32.push_back(33'(a32) + 33'(b32) + 33'(c32));
    end
  end

  // Output monitors: compare on every output handshake.
  always @(negedge clk) begin
    if (rst8_n && ov8 && or8) begin
      if (q8.size() == 0) begin
        check("sb8_unexpected", 65'(1), 65'(0));
      end else begin
        check("sb8", 65'({co8, s8}), 65'(q8.pop_front()));
      end
      res8++;
    end
    if (rst32_n && ov32 && or32) begin
      if (q32.size() == 0) begin
        check("sb32_unexpected", 65'(1), 65'(0));
      end else begin
        check("sb32", 65'({co32, s32}), 65'(q32.pop_front()));
      end
      res32++;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Issue one request on dut8; returns just after the accepting edge.
  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic c);
    int n;
    iv8 = 1'b1; a8 = a; b8 = b; c8 = c;
    n = 0;
    while (!ir8 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (!ir8) check("send8_timeout", 65'(0), 65'(1));
    @(posedge clk); #1;
    iv8 = 1'b0;
  endtask

  task automatic wait_valid8(output int cyc);
    cyc = 0;
    while (!ov8 && cyc < 200) begin
      @(posedge clk); #1; cyc++;
    end
  endtask

  task automatic run8(input string name, input logic [7:0] a, input logic [7:0] b,
                      input logic c, input logic [7:0] es, input logic ec);
    int cyc;
    or8 = 1'b0;
    send8(a, b, c);
    wait_valid8(cyc);
    check({name, "_latency"}, 65'(cyc), 65'(8));
    check({name, "_sum"}, 65'(s8), 65'(es));
    check({name, "_carry"}, 65'(co8), 65'(ec));
    or8 = 1'b1;
    @(posedge clk); #1;
    or8 = 1'b0;
  endtask

  task automatic test8();
    int cyc;
    int n;
    int start;
    run8("basic", 8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0);
    run8("overflow", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    run8("allones_cin", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);

    // Backpressure: 0xC3 + 0x5E + 1 = 0x122
    send8(8'hC3, 8'h5E, 1'b1);
    wait_valid8(cyc);
    check("bp_latency", 65'(cyc), 65'(8));
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_sum_hold", 65'(s8), 65'(8'h22));
      check("bp_carry_hold", 65'(co8), 65'(1));
      check("bp_in_ready_low", 65'(ir8), 65'(0));
      check("bp_out_valid_high", 65'(ov8), 65'(1));
    end
    or8 = 1'b1;
    @(posedge clk); #1;
    check("bp_release_in_ready", 65'(ir8), 65'(1));
    or8 = 1'b0;

    // Reset in the middle of Busy.
    send8(8'h77, 8'h11, 1'b1);
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst8_n = 1'b0;
    #1;
    q8.delete();
    check("rst_mid_in_ready", 65'(ir8), 65'(1));
    check("rst_mid_out_valid", 65'(ov8), 65'(0));
    check("rst_mid_sum", 65'(s8), 65'(0));
    check("rst_mid_carry", 65'(co8), 65'(0));
    @(negedge clk);
    rst8_n = 1'b1;
    @(posedge clk); #1;
    run8("after_rst", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0);

    // Stress: in_valid held high, random out_ready.
    start = res8;
    iv8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
    n = 0;
    for (int sent = 0; sent < 200 && n < 20000; ) begin
      logic acc;
      @(negedge clk);
      acc = ir8 && iv8;
      @(posedge clk); #1;
      n++;
      if (acc) begin
        sent++;
        a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
      end
      or8 = 1'($urandom_range(0, 1));
    end
    iv8 = 1'b0;
    or8 = 1'b1;
    n = 0;
    while ((q8.size() != 0 || ov8) && n < 2000) begin
      @(posedge clk); #1; n++;
    end
    check("stress8_drained", 65'(q8.size()), 65'(0));
    check("stress8_count", 65'(res8 - start), 65'(200));
  endtask

  task automatic test32();
    int n;
    int sent;
    iv32 = 1'b1; a32 = $urandom; b32 = $urandom; c32 = 1'($urandom);
    n = 0;
    sent = 0;
    while (sent < 100 && n < 30000) begin
      logic acc;
      @(negedge clk);
      acc = ir32 && iv32;
      @(posedge clk); #1;
      n++;
      if (acc) begin
        sent++;
        // Mix in extreme operands to exercise full carry ripple.
        a32 = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
        b32 = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
        c32 = 1'($urandom);
      end
      or32 = 1'($urandom_range(0, 1));
    end
    check("stress32_sent", 65'(sent), 65'(100));
    iv32 = 1'b0;
    or32 = 1'b1;
    n = 0;
    while ((q32.size() != 0 || ov32) && n < 2000) begin
      @(posedge clk); #1; n++;
    end
    check("stress32_drained", 65'(q32.size()), 65'(0));
    check("stress32_count", 65'(res32), 65'(100));
  endtask

  initial begin
    rst8_n = 1'b0; iv8 = 1'b0; or8 = 1'b0; a8 = '0; b8 = '0; c8 = 1'b0;
    rst32_n = 1'b0; iv32 = 1'b0; or32 = 1'b0; a32 = '0; b32 = '0; c32 = 1'b0;
    #12;
    check("reset_in_ready", 65'(ir8), 65'(1));
    check("reset_out_valid", 65'(ov8), 65'(0));
    check("reset_sum", 65'(s8), 65'(0));
    check("reset_carry", 65'(co8), 65'(0));
    check("reset32_in_ready", 65'(ir32), 65'(1));
    check("reset32_out_valid", 65'(ov32), 65'(0));
    @(negedge clk);
    rst8_n = 1'b1;
    rst32_n = 1'b1;
    @(posedge clk); #1;
    fork
      test8();
      test32();
    join
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
